// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ULA arithmetic/logic unit:
//   - default widths for the opcode (ULA_OP_DEF) and data path (BITS_DEF)
//   - opcode constants OP_ADD..OP_SRL (low three opcode bits)
//   - ula_flags_t, the packed {zero, carry, neg} flag word
// Optional feature macro used by the codebase: ULA_SHIFT_EN (enables SLL/SRL).
// -----------------------------------------------------------------------------
package ula_pkg;

  localparam int ULA_OP_DEF = 3;
  localparam int BITS_DEF   = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
  } ula_flags_t;

endpackage

// File: rtl/ula_flag_reg.sv
// -----------------------------------------------------------------------------
// ula_flag_reg
// Three-bit status flag register for the ULA.
// Ports:
//   clk_in    - clock, rising edge
//   rst_n_in  - synchronous active-low reset, clears all flags, wins over we_in
//   we_in     - load enable; flags hold when low
//   flags_in  - next flag word {zero, carry, neg}
//   flags_out - registered flag word
// Feature macro of the ULA codebase: ULA_SHIFT_EN (not used in this file).
// -----------------------------------------------------------------------------
module ula_flag_reg
  import ula_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       we_in,
  input  ula_flags_t flags_in,
  output ula_flags_t flags_out
);

  ula_flags_t r_flags;

  // Flag storage: synchronous clear, otherwise load on enable, else hold.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_flags <= 3'b000;
    end else if (we_in) begin
      r_flags <= flags_in;
    end else begin
      r_flags <= r_flags;
    end
  end

  assign flags_out = r_flags;

endmodule

// File: rtl/ula.sv
// -----------------------------------------------------------------------------
// ula
// Combinational arithmetic/logic unit with a registered status flag set.
// Parameters:
//   ULA_OP - opcode width (>= 3); opcodes >= 8 yield result 0, carry 0
//   BITS   - operand/result width (>= 2, power of two)
// Ports:
//   clk_in, rst_n_in  - clock and synchronous active-low reset (flags only)
//   a_in, b_in        - unsigned operands
//   ula_op_in         - operation select
//   flag_we_in        - flag register load enable
//   result_out        - combinational result
//   zero_out, carry_out, neg_out - registered flags
// Macro ULA_SHIFT_EN: when defined, opcodes 6/7 are logical shifts by
// b_in[log2(BITS)-1:0]; when undefined they return 0 and no shifter exists.
// -----------------------------------------------------------------------------
module ula
  import ula_pkg::*;
#(
  parameter int ULA_OP = ULA_OP_DEF,
  parameter int BITS   = BITS_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [BITS-1:0]   a_in,
  input  logic [BITS-1:0]   b_in,
  input  logic [ULA_OP-1:0] ula_op_in,
  input  logic              flag_we_in,
  output logic [BITS-1:0]   result_out,
  output logic              zero_out,
  output logic              carry_out,
  output logic              neg_out
);

  logic [BITS:0]   w_sum;
  logic [BITS:0]   w_diff;
  logic [2:0]      w_op_lo;
  logic            w_op_bad;
  logic [BITS-1:0] w_result;
  logic            w_carry;
  ula_flags_t      w_flags_next;
  ula_flags_t      w_flags;

`ifdef ULA_SHIFT_EN
  localparam int SHW = $clog2(BITS);
  logic [SHW-1:0] w_shamt;
  assign w_shamt = b_in[SHW-1:0];
`endif

  // One extra bit holds the ADD carry-out / SUB borrow (set when a < b).
  assign w_sum    = {1'b0, a_in} + {1'b0, b_in};
  assign w_diff   = {1'b0, a_in} - {1'b0, b_in};
  assign w_op_lo  = ula_op_in[2:0];
  // Any opcode bit above bit 2 marks an undefined operation.
  assign w_op_bad = ((ula_op_in >> 3'd3) != '0);

  // Result and carry selection by opcode.
  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    if (w_op_bad) begin
      w_result = '0;
      w_carry  = 1'b0;
    end else begin
      case (w_op_lo)
        OP_ADD: begin
          w_result = w_sum[BITS-1:0];
          w_carry  = w_sum[BITS];
        end
        OP_SUB: begin
          w_result = w_diff[BITS-1:0];
          w_carry  = w_diff[BITS];
        end
        OP_OR:  w_result = a_in | b_in;
        OP_AND: w_result = a_in & b_in;
        OP_XOR: w_result = a_in ^ b_in;
        OP_NOT: w_result = ~a_in;
`ifdef ULA_SHIFT_EN
        OP_SLL: w_result = a_in << w_shamt;
        OP_SRL: w_result = a_in >> w_shamt;
`else
        OP_SLL: w_result = '0;
        OP_SRL: w_result = '0;
`endif
        default: begin
          w_result = '0;
          w_carry  = 1'b0;
        end
      endcase
    end
  end

  assign w_flags_next.zero  = (w_result == '0);
  assign w_flags_next.carry = w_carry;
  assign w_flags_next.neg   = w_result[BITS-1];

  ula_flag_reg u_flag_reg (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .we_in     (flag_we_in),
    .flags_in  (w_flags_next),
    .flags_out (w_flags)
  );

  assign result_out = w_result;
  assign zero_out   = w_flags.zero;
  assign carry_out  = w_flags.carry;
  assign neg_out    = w_flags.neg;

endmodule

// File: tb/tb_ula.sv
// -----------------------------------------------------------------------------
// tb_ula
// Self-checking bench for ula (BITS=8, ULA_OP=4 so undefined opcodes exist).
// The reference model works on plain integers; shift expectations follow the
// ULA_SHIFT_EN macro as the DUT does.
// -----------------------------------------------------------------------------
module tb_ula;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       we;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       neg;

  int checks   = 0;
  int failures = 0;

  // Expected flag state kept by the bench.
  int exp_z = 0;
  int exp_c = 0;
  int exp_n = 0;

  always #5 clk = ~clk;

  ula #(.ULA_OP(4), .BITS(8)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .a_in       (a),
    .b_in       (b),
    .ula_op_in  (op),
    .flag_we_in (we),
    .result_out (result),
    .zero_out   (zero),
    .carry_out  (carry),
    .neg_out    (neg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (a=%0h b=%0h op=%0d)", tag, got, exp, a, b, op);
    end
  endtask

  // Reference: arithmetic on integers straight from the opcode table.
  function automatic void model(input int av, input int bv, input int opv,
                                output int r, output int c);
    int sh;
    sh = bv % 8;
    r = 0;
    c = 0;
    case (opv)
      0: begin r = (av + bv) % 256; c = (av + bv > 255) ? 1 : 0; end
      1: begin r = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0; end
      2: r = av | bv;
      3: r = av & bv;
      4: r = av ^ bv;
      5: r = 255 - av;
`ifdef ULA_SHIFT_EN
      6: r = (av * (1 << sh)) % 256;
      7: r = av / (1 << sh);
`endif
      default: begin r = 0; c = 0; end
    endcase
  endfunction

  // Apply one set of inputs, check the combinational result, clock once,
  // then check the flags against the model.
  task automatic step(input int av, input int bv, input int opv,
                      input logic wev, input logic rstv, input string tag);
    int r;
    int c;
    logic [31:0] tmp;
    @(negedge clk);
    tmp   = av;
    a     = tmp[7:0];
    tmp   = bv;
    b     = tmp[7:0];
    tmp   = opv;
    op    = tmp[3:0];
    we    = wev;
    rst_n = rstv;
    #1;
    model(av, bv, opv, r, c);
    chk({tag, "_result"}, {24'd0, result}, r);
    if (!rstv) begin
      exp_z = 0; exp_c = 0; exp_n = 0;
    end else if (wev) begin
      exp_z = (r == 0) ? 1 : 0;
      exp_c = c;
      exp_n = (r >= 128) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    chk({tag, "_zero"},  {31'd0, zero},  exp_z);
    chk({tag, "_carry"}, {31'd0, carry}, exp_c);
    chk({tag, "_neg"},   {31'd0, neg},   exp_n);
  endtask

  initial begin
    int av;
    int bv;
    rst_n = 1'b0;
    we    = 1'b1;
    a     = 8'd0;
    b     = 8'd0;
    op    = 4'd0;

    // Reset state (flags clear even with write enable high).
    step(8'hFF, 8'h01, 0, 1'b1, 1'b0, "reset");
    step(8'h10, 8'h20, 2, 1'b1, 1'b0, "reset2");

    // Exhaustive OR sweep, no clock dependence, flags held.
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b0;
    op    = 4'd2;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        a = i[7:0];
        b = j[7:0];
        #1;
        chk("or_sweep", {24'd0, result}, i | j);
      end
    end

    // Directed cases.
    step(8'hFF, 8'h01, 0, 1'b1, 1'b1, "add_wrap");
    chk("add_wrap_z_const", {31'd0, zero}, 1);
    chk("add_wrap_c_const", {31'd0, carry}, 1);
    step(8'h03, 8'h05, 1, 1'b1, 1'b1, "sub_borrow");
    chk("sub_borrow_res_const", {24'd0, result}, 8'hFE);
    chk("sub_borrow_n_const", {31'd0, neg}, 1);

    @(negedge clk);
    a = 8'h81; b = 8'h09; op = 4'd6; we = 1'b0;
    #1;
`ifdef ULA_SHIFT_EN
    chk("sll_dir", {24'd0, result}, 8'h02);
`else
    chk("sll_dir", {24'd0, result}, 8'h00);
`endif
    step(8'h81, 8'h09, 6, 1'b0, 1'b1, "sll");
    step(8'h81, 8'h0B, 7, 1'b1, 1'b1, "srl");
    step(8'h55, 8'h0F, 8, 1'b1, 1'b1, "undef_op");
    step(8'hF0, 8'h0F, 15, 1'b1, 1'b1, "undef_op15");

    // Flags set, then reset overrides enable, then hold with enable low.
    step(8'h03, 8'h05, 1, 1'b1, 1'b1, "set_flags");
    step(8'h00, 8'h00, 0, 1'b1, 1'b0, "rst_over_we");
    step(8'h7F, 8'h01, 0, 1'b0, 1'b1, "hold_after_rst");
    step(8'h80, 8'h80, 0, 1'b1, 1'b1, "set_zc");
    step(8'h01, 8'h01, 2, 1'b0, 1'b1, "hold1");
    step(8'h00, 8'h01, 1, 1'b0, 1'b1, "hold2");
    step(8'h05, 8'h05, 1, 1'b1, 1'b1, "sub_equal");
    step(8'h00, 8'h00, 5, 1'b1, 1'b1, "not_zero");

    // Randomized stimulus against the model.
    for (int k = 0; k < 400; k++) begin
      av = (k % 7 == 0) ? 0 : int'($urandom_range(0, 255));
      bv = (k % 5 == 0) ? av : int'($urandom_range(0, 255));
      step(av, bv, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula.md
ULA -- requirements
Module: ula

Interface
REQ-001 Parameter ULA_OP, default 3, SHALL set the opcode width in bits (ULA_OP >= 3).
REQ-002 Parameter BITS, default 8, SHALL set the operand/result width in bits (BITS >= 2, power of two).
REQ-003 clk_in  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n_in  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 a_in  input  BITS  SHALL be operand A (unsigned).
REQ-006 b_in  input  BITS  SHALL be operand B (unsigned).
REQ-007 ula_op_in  input  ULA_OP  SHALL select the operation.
REQ-008 flag_we_in  input  1  SHALL enable the flag-register update when high.
REQ-009 result_out  output  BITS  SHALL be the operation result, purely combinational.
REQ-010 zero_out  output  1  SHALL be the registered zero flag.
REQ-011 carry_out  output  1  SHALL be the registered carry/borrow flag.
REQ-012 neg_out  output  1  SHALL be the registered negative flag.

Function
REQ-013 result_out SHALL follow a_in, b_in and ula_op_in with zero clock latency, independent of clk_in and rst_n_in.
REQ-014 Opcodes SHALL be: 0 ADD a+b; 1 SUB a-b; 2 OR a|b; 3 AND a&b; 4 XOR a^b; 5 NOT ~a; 6 SLL a<<b; 7 SRL a>>b (logical).
REQ-015 ADD/SUB SHALL wrap modulo 2^BITS; next carry = ADD carry-out bit BITS, SUB borrow (1 when a < b unsigned).
REQ-016 Carry SHALL be computed as 0 for all non-ADD/SUB opcodes.
REQ-017 Shift amount SHALL be b_in[log2(BITS)-1:0]; upper b_in bits SHALL be ignored.
REQ-018 Opcodes >= 8 (when ULA_OP > 3) SHALL produce result_out = 0 and computed carry 0.
REQ-019 On a rising edge with rst_n_in high and flag_we_in high, flags SHALL load: zero = (result == 0), carry per REQ-015/016, neg = result[BITS-1].
REQ-020 With flag_we_in low, flags SHALL hold; flags SHALL never affect result_out.

Reset
REQ-021 On a rising edge with rst_n_in low, zero_out, carry_out and neg_out SHALL become 0, overriding flag_we_in.
REQ-022 result_out SHALL remain a valid combinational function of its inputs during reset.

Configuration
REQ-023 Macro ULA_SHIFT_EN defined: opcodes 6 and 7 SHALL behave per REQ-014/017.
REQ-024 Macro ULA_SHIFT_EN undefined: opcodes 6 and 7 SHALL give result 0 and carry 0, and no shifter logic SHALL be synthesized.

Structure
REQ-025 Opcode constants (OP_ADD..OP_SRL) and defaults for ULA_OP/BITS SHALL live in the shared package/header used by the codebase.
REQ-026 The flag register SHALL be a sub-module ula_flag_reg (clock, reset, write enable, 3-bit flag in/out); datapath stays in ula.

Verification
REQ-027 Exhaustive BITS=8 sweep, op 2, all a,b in 0..255 -> result_out == a|b after settling, no clock needed.
REQ-028 Op 0, a=0xFF, b=0x01, flag_we_in=1, one edge -> result 0x00, zero=1, carry=1, neg=0.
REQ-029 Op 1, a=0x03, b=0x05, flag_we_in=1, one edge -> result 0xFE, carry=1, neg=1, zero=0.
REQ-030 Op 6, a=0x81, b=0x09 with ULA_SHIFT_EN -> result 0x02; without it -> 0x00.
REQ-031 Flags set, then rst_n_in=0 with flag_we_in=1 over one edge -> all flags 0; flag_we_in=0 on later edges -> flags hold.
